jzjpcc_execute_stage: RTL
=========================

JZJPCC_EXECUTE_STAGE -- requirements
Module: jzjpcc_execute_stage

Interface
REQ-001 SHALL have parameter PC_MAX_B, default 15, meaning the MSB index of the word-aligned PC (PC bits [PC_MAX_B:2]).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-004 SHALL have port fromDecode  in  jzjpcc_execute_if.execute modport  immediate, rs1, rs2, currentPC, rdAddr, aluOperation, aluMod, aluMuxMode, memoryWriteEnable, rdSource, rdWriteEnable.
REQ-005 SHALL have port stall  in  1  hold the ID/EX register and issue a bubble into EX/MEM.
REQ-006 SHALL have port flush  in  1  load a bubble into the ID/EX register.
REQ-007 SHALL have ports wbRdAddr  in  5, wbRdWriteEnable  in  1 and wbRdData  in  32, carrying writeback-stage forwarding data.
REQ-008 SHALL have ports aluResult_memory  out  32, rs2_memory  out  32, rdAddr_memory  out  5, memoryWriteEnable_memory  out  1, rdSource_memory  out  1 and rdWriteEnable_memory  out  1, forming the EX/MEM register.
REQ-009 SHALL have port loadUseHazard  out  1  combinational; the ID/EX source register needs a load result still in EX/MEM.

Function
REQ-010 ID/EX register SHALL capture all fromDecode fields on every edge with stall=0 and flush=0.
REQ-011 flush=1 SHALL load a bubble (rdWriteEnable=0, memoryWriteEnable=0, rdAddr=0, remaining fields 0); flush SHALL take priority over stall.
REQ-012 stall=1 with flush=0 SHALL hold ID/EX unchanged and load an EX/MEM bubble (both write enables 0, all other fields 0).
REQ-013 Otherwise EX/MEM SHALL capture the ALU result, forwarded rs2, rdAddr and control bits from ID/EX; decode-to-memory latency SHALL be 2 edges.
REQ-014 Operand A SHALL be: aluMuxMode 00/01 forwarded rs1; 10 {zero-extended currentPC, 2'b00}; 11 zero.
REQ-015 Operand B SHALL be: aluMuxMode 00 forwarded rs2; 01/10/11 immediate.
REQ-016 aluOperation SHALL select: 000 add (aluMod=1: A-B); 001 A<<B[4:0]; 010 signed A<B -> 1/0; 011 unsigned A<B; 100 xor; 101 logical >> (aluMod=1: arithmetic); 110 or; 111 and.
REQ-017 aluMod SHALL be obeyed verbatim for 000/101 and ignored otherwise; arithmetic SHALL wrap modulo 2^32 with no flags.
REQ-018 Forwarded rs1/rs2 SHALL use EX/MEM aluResult when rdAddr_memory matches, rdWriteEnable_memory=1, rdSource_memory=0.
REQ-019 Forwarded rs1/rs2 SHALL otherwise use wbRdData when wbRdAddr matches and wbRdWriteEnable=1, else the ID/EX value; EX/MEM SHALL take priority over writeback.
REQ-020 Register address 0 SHALL never be forwarded and SHALL never raise a hazard.
REQ-021 loadUseHazard SHALL be 1 iff rdWriteEnable_memory=1, rdSource_memory=1 and rdAddr_memory is nonzero and equals ID/EX rs1Addr or rs2Addr; ID/EX therefore SHALL also store rs1Addr/rs2Addr (5 bits each) taken from decode alongside rdAddr.
REQ-022 Forwarding SHALL be re-evaluated every cycle while stalled, so a held instruction picks up writeback data on the cycle it resolves.
REQ-023 rs2_memory SHALL carry the forwarded rs2, not the raw ID/EX rs2.

Reset
REQ-024 reset=0 at an edge SHALL clear the ID/EX and EX/MEM registers to all-zero, so every output reads 0 and loadUseHazard reads 0.
REQ-025 reset SHALL override stall and flush; an instruction in flight when reset asserts SHALL be discarded with no write enable surviving.
REQ-026 The first instruction presented on the edge where reset=1 is first sampled SHALL be captured normally.

Verification
REQ-027 Add: rs1=5, rs2=7, aluMuxMode=00, op=000, aluMod=0, rdAddr=3, rdWriteEnable=1 -> 2 edges later aluResult_memory=12, rdAddr_memory=3, rdWriteEnable_memory=1.
REQ-028 AUIPC/SRA: currentPC=0x10 (PC 0x40), imm=0x1000, mode 10 -> result 0x1040; rs1=0x80000000, imm=4, op=101, aluMod=1, mode 01 -> 0xF8000000.
REQ-029 Forward priority: EX/MEM writes x5=100 as an ALU result and writeback writes x5=200 -> next instruction reading rs1=x5 uses 100; with x0 as destination, the stale ID/EX value is used.
REQ-030 Load-use: EX/MEM holds a load to x6 (rdSource=1) and ID/EX reads x6 -> loadUseHazard=1; drive stall=1 for 1 cycle, giving an EX/MEM bubble; wbRdData=0x55 then forwarded and result correct.
REQ-031 stall=1 and flush=1 together -> ID/EX bubble and EX/MEM bubble; no write enable asserted 2 edges later.
REQ-032 reset=0 mid-stream with memoryWriteEnable_memory=1 -> all outputs 0 after the edge; the first instruction after reset release completes correctly.

Source files
------------

// File: rtl/jzjpcc_execute_stage_if.sv
// Decode-to-execute bundle for the jzjpcc pipeline.
// Carries one decoded instruction: operand values, immediate, word-aligned PC,
// register addresses and the ALU / memory / writeback control fields.
// Modports: decode drives the bundle, execute samples it.
interface jzjpcc_execute_if #(
    parameter int PC_MAX_B = 15
);
    logic [31:0]       immediate;
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    logic [PC_MAX_B:2] currentPC;
    logic [4:0]        rdAddr;
    logic [4:0]        rs1Addr;
    logic [4:0]        rs2Addr;
    logic [2:0]        aluOperation;
    logic              aluMod;
    logic [1:0]        aluMuxMode;
    logic              memoryWriteEnable;
    logic              rdSource;
    logic              rdWriteEnable;

    modport execute (
        input immediate, rs1, rs2, currentPC, rdAddr, rs1Addr, rs2Addr,
              aluOperation, aluMod, aluMuxMode, memoryWriteEnable, rdSource,
              rdWriteEnable
    );

    modport decode (
        output immediate, rs1, rs2, currentPC, rdAddr, rs1Addr, rs2Addr,
               aluOperation, aluMod, aluMuxMode, memoryWriteEnable, rdSource,
               rdWriteEnable
    );
endinterface

// File: rtl/jzjpcc_execute_stage.sv
// Execute stage of the jzjpcc pipeline: ID/EX register, operand forwarding,
// ALU, load-use hazard detection and the EX/MEM register.
// Ports:
//   clock, reset          sole clock; synchronous active-low reset
//   fromDecode            decoded instruction (execute modport)
//   stall                 hold ID/EX, push a bubble into EX/MEM
//   flush                 push a bubble into ID/EX (wins over stall)
//   wbRdAddr/WriteEnable/Data   writeback-stage forwarding source
//   *_memory              EX/MEM register outputs
//   loadUseHazard         ID/EX reads a register still being loaded in EX/MEM
module jzjpcc_execute_stage #(
    parameter int PC_MAX_B = 15
) (
    input  logic        clock,
    input  logic        reset,
    jzjpcc_execute_if.execute fromDecode,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  wbRdAddr,
    input  logic        wbRdWriteEnable,
    input  logic [31:0] wbRdData,
    output logic [31:0] aluResult_memory,
    output logic [31:0] rs2_memory,
    output logic [4:0]  rdAddr_memory,
    output logic        memoryWriteEnable_memory,
    output logic        rdSource_memory,
    output logic        rdWriteEnable_memory,
    output logic        loadUseHazard
);
    typedef struct packed {
        logic [31:0]       immediate;
        logic [31:0]       rs1;
        logic [31:0]       rs2;
        logic [PC_MAX_B:2] pc;
        logic [4:0]        rd_addr;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [2:0]        alu_op;
        logic              alu_mod;
        logic [1:0]        mux_mode;
        logic              mem_we;
        logic              rd_source;
        logic              rd_we;
    } idex_t;

    idex_t       idex;
    idex_t       dec;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_out;

    always_comb begin
        dec           = '0;
        dec.immediate = fromDecode.immediate;
        dec.rs1       = fromDecode.rs1;
        dec.rs2       = fromDecode.rs2;
        dec.pc        = fromDecode.currentPC;
        dec.rd_addr   = fromDecode.rdAddr;
        dec.rs1_addr  = fromDecode.rs1Addr;
        dec.rs2_addr  = fromDecode.rs2Addr;
        dec.alu_op    = fromDecode.aluOperation;
        dec.alu_mod   = fromDecode.aluMod;
        dec.mux_mode  = fromDecode.aluMuxMode;
        dec.mem_we    = fromDecode.memoryWriteEnable;
        dec.rd_source = fromDecode.rdSource;
        dec.rd_we     = fromDecode.rdWriteEnable;
    end

    // A load in EX/MEM has no data yet, so only ALU results forward from there.
    function automatic logic [31:0] forward(
        input logic [4:0]  addr,
        input logic [31:0] raw,
        input logic [4:0]  mem_addr,
        input logic        mem_we,
        input logic        mem_src,
        input logic [31:0] mem_data,
        input logic [4:0]  wb_addr,
        input logic        wb_we,
        input logic [31:0] wb_data
    );
        logic [31:0] val;
        val = raw;
        if (addr != 5'd0) begin
            if (mem_we && !mem_src && (mem_addr == addr)) begin
                val = mem_data;
            end else if (wb_we && (wb_addr == addr)) begin
                val = wb_data;
            end
        end
        return val;
    endfunction

    always_comb begin
        fwd_rs1 = forward(idex.rs1_addr, idex.rs1, rdAddr_memory, rdWriteEnable_memory,
                          rdSource_memory, aluResult_memory, wbRdAddr, wbRdWriteEnable, wbRdData);
        fwd_rs2 = forward(idex.rs2_addr, idex.rs2, rdAddr_memory, rdWriteEnable_memory,
                          rdSource_memory, aluResult_memory, wbRdAddr, wbRdWriteEnable, wbRdData);
    end

    always_comb begin
        op_a = fwd_rs1;
        case (idex.mux_mode)
            2'b10:   op_a = 32'({idex.pc, 2'b00});
            2'b11:   op_a = 32'd0;
            default: op_a = fwd_rs1;
        endcase
        op_b = (idex.mux_mode == 2'b00) ? fwd_rs2 : idex.immediate;
    end

    always_comb begin
        alu_out = 32'd0;
        case (idex.alu_op)
            3'b000: alu_out = idex.alu_mod ? (op_a - op_b) : (op_a + op_b);
            3'b001: alu_out = op_a << op_b[4:0];
            3'b010: alu_out = {31'd0, ($signed(op_a) < $signed(op_b))};
            3'b011: alu_out = {31'd0, (op_a < op_b)};
            3'b100: alu_out = op_a ^ op_b;
            3'b101: alu_out = idex.alu_mod ? 32'($signed(op_a) >>> op_b[4:0])
                                           : (op_a >> op_b[4:0]);
            3'b110: alu_out = op_a | op_b;
            default: alu_out = op_a & op_b;
        endcase
    end

    always_comb begin
        loadUseHazard = rdWriteEnable_memory && rdSource_memory && (rdAddr_memory != 5'd0)
                        && ((rdAddr_memory == idex.rs1_addr) || (rdAddr_memory == idex.rs2_addr));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idex                     <= '0;
            aluResult_memory         <= 32'd0;
            rs2_memory               <= 32'd0;
            rdAddr_memory            <= 5'd0;
            memoryWriteEnable_memory <= 1'b0;
            rdSource_memory          <= 1'b0;
            rdWriteEnable_memory     <= 1'b0;
        end else begin
            if (flush) begin
                idex <= '0;
            end else if (!stall) begin
                idex <= dec;
            end

            if (stall) begin
                aluResult_memory         <= 32'd0;
                rs2_memory               <= 32'd0;
                rdAddr_memory            <= 5'd0;
                memoryWriteEnable_memory <= 1'b0;
                rdSource_memory          <= 1'b0;
                rdWriteEnable_memory     <= 1'b0;
            end else begin
                aluResult_memory         <= alu_out;
                rs2_memory               <= fwd_rs2;
                rdAddr_memory            <= idex.rd_addr;
                memoryWriteEnable_memory <= idex.mem_we;
                rdSource_memory          <= idex.rd_source;
                rdWriteEnable_memory     <= idex.rd_we;
            end
        end
    end
endmodule
